// File: rtl/ls08_selftest_seq.sv
// Self-test sequencer for an emulated SN74LS08 quad AND gate: walks the four
// {A,B} input pairs across all gates, waits for settling, checks Y = A & B.
module ls08_selftest_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] y,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic       fail_seen
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Counter reload of SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles in SETTLE.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic       HAS_SETTLE  = (SETTLE_CYCLES > 0);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec_idx;
    logic [3:0] settle_cnt;
    logic [3:0] mismatch;
    logic       last_check;

    // Vector v drives A = v[1], B = v[0] onto all four gates at once.
    function automatic logic [7:0] vec_pattern(input logic [1:0] v);
        return {{4{v[1]}}, {4{v[0]}}};
    endfunction

    assign mismatch   = y ^ (a & b);
    assign last_check = (state == CHECK) && !abort && (vec_idx == 2'd3);
    assign busy       = (state == APPLY) || (state == SETTLE) || (state == CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   begin
                if (abort)           state_nxt = IDLE;
                else if (HAS_SETTLE) state_nxt = SETTLE;
                else                 state_nxt = CHECK;
            end
            SETTLE:  begin
                if (abort)                  state_nxt = IDLE;
                else if (settle_cnt == 4'd0) state_nxt = CHECK;
            end
            CHECK:   begin
                if (abort)                 state_nxt = IDLE;
                else if (vec_idx == 2'd3)  state_nxt = DONE;
                else                       state_nxt = APPLY;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a              <= 4'd0;
            b              <= 4'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_mask      <= 4'd0;
            first_fail_vec <= 2'd0;
            fail_seen      <= 1'b0;
            vec_idx        <= 2'd0;
            settle_cnt     <= 4'd0;
        end else begin
            done <= last_check;
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_mask      <= 4'd0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= 2'd0;
                        pass           <= 1'b0;
                        vec_idx        <= 2'd0;
                        {a, b}         <= vec_pattern(2'd0);
                    end
                end
                APPLY: begin
                    if (abort) begin
                        a <= 4'd0;
                        b <= 4'd0;
                    end else begin
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        a <= 4'd0;
                        b <= 4'd0;
                    end else if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    // Abort wins over recording this vector's result.
                    if (abort) begin
                        a <= 4'd0;
                        b <= 4'd0;
                    end else begin
                        fail_mask <= fail_mask | mismatch;
                        if ((mismatch != 4'd0) && !fail_seen) begin
                            fail_seen      <= 1'b1;
                            first_fail_vec <= vec_idx;
                        end
                        if (vec_idx == 2'd3) begin
                            a    <= 4'd0;
                            b    <= 4'd0;
                            pass <= ((fail_mask | mismatch) == 4'd0);
                        end else begin
                            vec_idx <= vec_idx + 2'd1;
                            {a, b}  <= vec_pattern(vec_idx + 2'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ls08_selftest_seq.sv
// Bench for ls08_selftest_seq: a behavioural LS08 with stuck-at faults feeds y,
// two instances cover the default settle time and a zero settle time.
module tb_ls08_selftest_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1, abort0, abort1;
    logic [3:0] s0_mask, s1_mask;

    logic [3:0] a0, b0, y0, fm0;
    logic [3:0] a1, b1, y1, fm1;
    logic       busy0, done0, pass0, fs0;
    logic       busy1, done1, pass1, fs1;
    logic [1:0] ffv0, ffv1;

    always #5 clk = ~clk;

    // Gate model with per-gate stuck-at-0 / stuck-at-1 faults.
    assign y0 = ((a0 & b0) & ~s0_mask) | s1_mask;
    assign y1 = ((a1 & b1) & ~s0_mask) | s1_mask;

    ls08_selftest_seq #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .first_fail_vec(ffv0), .fail_seen(fs0)
    );

    ls08_selftest_seq #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fm1), .first_fail_vec(ffv1), .fail_seen(fs1)
    );

    int         sel = 0;
    logic [3:0] m_a, m_b, m_fm;
    logic       m_busy, m_done, m_pass, m_fs;
    logic [1:0] m_ffv;
    assign m_a    = (sel == 1) ? a1    : a0;
    assign m_b    = (sel == 1) ? b1    : b0;
    assign m_busy = (sel == 1) ? busy1 : busy0;
    assign m_done = (sel == 1) ? done1 : done0;
    assign m_pass = (sel == 1) ? pass1 : pass0;
    assign m_fm   = (sel == 1) ? fm1   : fm0;
    assign m_ffv  = (sel == 1) ? ffv1  : ffv0;
    assign m_fs   = (sel == 1) ? fs1   : fs0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] a_log [0:31];
    logic [3:0] b_log [0:31];
    logic       pass_c1;

    // Pulse start on the selected instance and log 30 cycles after acceptance.
    task automatic run_test(input int inst, output int busy_n, output int done_n, output int done_at);
        sel     = inst;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0  = 1'b0;
        start1  = 1'b0;
        pass_c1 = m_pass;
        for (int i = 1; i <= 30; i++) begin
            if (m_busy) busy_n++;
            if (m_done) begin
                done_n++;
                done_at = i;
            end
            a_log[i] = m_a;
            b_log[i] = m_b;
            step();
        end
    endtask

    typedef struct {
        int         inst;
        logic [3:0] s0;
        logic [3:0] s1;
        int         settle;
        logic       exp_pass;
        logic [3:0] exp_mask;
        logic       exp_seen;
        logic [1:0] exp_ffv;
    } vec_t;

    vec_t tbl [0:6];

    initial begin
        int bn, dn, da, per;
        logic [3:0] ea, eb;

        tbl[0] = '{0, 4'h0, 4'h0, 2, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[1] = '{0, 4'h8, 4'h0, 2, 1'b0, 4'h8, 1'b1, 2'd3};
        tbl[2] = '{0, 4'h0, 4'h1, 2, 1'b0, 4'h1, 1'b1, 2'd0};
        tbl[3] = '{0, 4'h0, 4'h0, 2, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[4] = '{1, 4'h0, 4'h0, 0, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[5] = '{1, 4'h0, 4'hF, 0, 1'b0, 4'hF, 1'b1, 2'd0};
        tbl[6] = '{0, 4'h2, 4'h4, 2, 1'b0, 4'h6, 1'b1, 2'd0};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        s0_mask = 4'h0; s1_mask = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs0", {a0, b0, busy0, done0, pass0, fm0, ffv0, fs0}, 32'd0);
        chk("reset_outputs1", {a1, b1, busy1, done1, pass1, fm1, ffv1, fs1}, 32'd0);
        #4 rst_n = 1'b1;
        step();

        for (int t = 0; t < 7; t++) begin
            s0_mask = tbl[t].s0;
            s1_mask = tbl[t].s1;
            run_test(tbl[t].inst, bn, dn, da);
            per = tbl[t].settle + 2;
            chk($sformatf("busy_cycles[%0d]", t), bn, 4 * per);
            chk($sformatf("done_count[%0d]", t), dn, 1);
            chk($sformatf("done_cycle[%0d]", t), da, 4 * per + 1);
            chk($sformatf("pass_cleared[%0d]", t), pass_c1, 1'b0);
            for (int k = 0; k < 4; k++) begin
                ea = (k >= 2) ? 4'hF : 4'h0;
                eb = (k % 2 == 1) ? 4'hF : 4'h0;
                chk($sformatf("a_vec%0d[%0d]", k, t), a_log[1 + k * per], ea);
                chk($sformatf("b_vec%0d[%0d]", k, t), b_log[1 + k * per], eb);
            end
            chk($sformatf("ab_at_done[%0d]", t), {a_log[4 * per + 1], b_log[4 * per + 1]}, 8'h00);
            chk($sformatf("pass[%0d]", t), m_pass, tbl[t].exp_pass);
            chk($sformatf("fail_mask[%0d]", t), m_fm, tbl[t].exp_mask);
            chk($sformatf("fail_seen[%0d]", t), m_fs, tbl[t].exp_seen);
            chk($sformatf("first_fail_vec[%0d]", t), m_ffv, tbl[t].exp_ffv);
        end

        // Repeated start during a run, then abort in SETTLE of vector 2.
        sel = 0; s0_mask = 4'h0; s1_mask = 4'h1; dn = 0;
        start0 = 1'b1;
        step();
        for (int i = 1; i <= 9; i++) begin
            start0 = (i == 3 || i == 6);
            if (done0) dn++;
            step();
        end
        start0 = 1'b0;
        chk("abort_pre_busy", busy0, 1'b1);
        chk("abort_pre_ab", {a0, b0}, 8'hF0);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_ab", {a0, b0}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (done0) dn++;
            step();
        end
        chk("abort_no_done", dn, 0);
        chk("abort_pass", pass0, 1'b0);
        chk("abort_partial_mask", fm0, 4'h1);
        chk("abort_partial_seen", fs0, 1'b1);

        // Start while in DONE is ignored.
        s1_mask = 4'h0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 1; i < 17; i++) step();
        chk("done_cycle17", done0, 1'b1);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("start_in_done_busy18", busy0, 1'b0);
        step();
        chk("start_in_done_busy19", busy0, 1'b0);
        chk("start_in_done_pass", pass0, 1'b1);

        // Async reset during CHECK of vector 1.
        s1_mask = 4'h1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 1; i < 8; i++) step();
        chk("pre_reset_busy", busy0, 1'b1);
        chk("pre_reset_seen", fs0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {a0, b0, busy0, done0, pass0, fm0, ffv0, fs0}, 32'd0);
        #1 rst_n = 1'b1;
        s1_mask = 4'h0;
        step();
        run_test(0, bn, dn, da);
        chk("post_reset_busy", bn, 16);
        chk("post_reset_done", dn, 1);
        chk("post_reset_pass", pass0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ls08_selftest_seq.md
Name: ls08_selftest_seq

Overview:
Self-test sequencer for the emulated quad 2-input AND IC (SN74LS08). On a start pulse it drives the four A/B gate input pairs through the full truth table, waits a settle interval, and samples the four Y outputs. Each Y is compared against A AND B, and the block reports per-gate pass/fail. It sits between the board-level test controller and the SN74LS08 instance, and owns the gate inputs while it is busy.

Parameters:
SETTLE_CYCLES, 2, number of clocks between applying a vector and sampling Y; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to run the self-test; sampled only in IDLE
abort  input  1  terminates a running test; return to IDLE without a done pulse
y  input  4  gate outputs Y4..Y1 from the SN74LS08 instance (bit0 = Y1)
a  output  4  drive to A4..A1 (bit0 = A1), registered
b  output  4  drive to B4..B1 (bit0 = B1), registered
busy  output  1  high while in APPLY, SETTLE or CHECK
done  output  1  one-cycle pulse when all four vectors have been checked
pass  output  1  1 when fail_mask==0; valid from the done pulse until the next accepted start
fail_mask  output  4  sticky per-gate failure flags; bit n set if Y(n+1) mismatched on any vector
first_fail_vec  output  2  index {A,B} of the first vector that produced any mismatch
fail_seen  output  1  1 once any mismatch has been recorded in the current run

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, first_fail_vec=0, fail_seen=0.
  - Vector index and settle counter are cleared.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE -> APPLY when start=1:
  - Clear fail_mask, fail_seen, first_fail_vec and pass.
  - Set vector index to 0.
  - Load a/b with the vector 0 pattern on the same edge.
- Vector index v = 0..3 maps to {A,B} = {v[1],v[0]}. The same pair is driven on all four gates: a = {4{v[1]}}, b = {4{v[0]}}.
- APPLY: one cycle. Go to SETTLE if SETTLE_CYCLES>0, else to CHECK. Load the settle counter with SETTLE_CYCLES-1.
- SETTLE:
  - Decrement the counter each cycle.
  - Go to CHECK on the cycle the counter equals 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK: one cycle; sample y.
  - mismatch = y XOR (a AND b).
  - fail_mask |= mismatch.
  - If mismatch!=0 and fail_seen==0: set fail_seen=1 and first_fail_vec=v.
  - If v==3, go to DONE. Otherwise increment v, load the next vector into a/b on the same edge, and go to APPLY.
- DONE: one cycle.
  - done=1, pass=(fail_mask==0), a=0, b=0.
  - Then go to IDLE.
  - pass, fail_mask, fail_seen and first_fail_vec hold until the next accepted start.
- Per-vector time is SETTLE_CYCLES+2 clocks; total run time is 4*(SETTLE_CYCLES+2) clocks.
  - done asserts in cycle 4*(SETTLE_CYCLES+2)+1 after the start edge; this is cycle 17 for the default.
- start while busy or in DONE: ignored; no restart and no effect on results.
- abort=1 in APPLY, SETTLE or CHECK:
  - Next state is IDLE; a=0, b=0, busy=0.
  - No done pulse is issued; pass stays 0.
  - fail_mask and fail_seen keep their partial values.
  - abort has priority over the CHECK update in the same cycle.
- abort in IDLE or DONE: no effect. start and abort high together in IDLE: start wins.
- Async reset mid-run: all outputs return immediately to their reset values; no done pulse.
- y is never sampled outside CHECK.

Test Plan:
- Correct AND model on y, default SETTLE_CYCLES=2, start pulse -> busy high for 16 cycles; a/b step through 0/0, 0/F, F/0, F/F; done pulse once; pass=1, fail_mask=0000, fail_seen=0.
- Model with Y4 stuck-at-0 -> done with pass=0, fail_mask=1000, fail_seen=1, first_fail_vec=11.
- Model with Y1 stuck-at-1 -> fail_mask=0001, first_fail_vec=00; a second clean run after start clears the flags and ends with pass=1.
- Repeated start pulses during a run plus abort asserted in SETTLE of vector 2 -> start has no effect; next cycle is IDLE with a=b=0 and busy=0; no done pulse; pass=0.
- rst_n driven low during CHECK of vector 1 -> all outputs are 0 asynchronously (before the next clock edge); a later start runs a complete 16-cycle test.
- SETTLE_CYCLES=0 instance with a correct model -> run takes 8 cycles (APPLY/CHECK alternating); pass=1.
